spm_memory_unit: RTL and testbench

//   Memory-side responder for the RISC_SPM memory bus (address/data_in/write out, data_out in).

---
 rtl/spm_pkg.sv | 23 ++
 rtl/spm_load_ctrl.sv | 132 +++++++++++++
 rtl/spm_memory_unit.sv | 89 ++++++++
 tb/tb_spm_memory_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// ---------------------------------------------------------------------------
// spm_pkg
//   Shared definitions for the RISC_SPM memory unit: default word/address
//   widths and the loader/run state encoding seen by the controller and the
//   top-level array wrapper.
// ---------------------------------------------------------------------------
package spm_pkg;

  localparam int WORD_SIZE = 8;
  localparam int ADDR_SIZE = 8;

  // IDLE : after reset, CPU held, waiting for the first image
  // LOAD : loader owns the write port, words accepted every cycle
  // DONE : one-cycle settle before the CPU is released
  // RUN  : CPU owns the array, loader ignored except for ld_start
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } spm_mem_state_t;

endpackage : spm_pkg

// File: rtl/spm_load_ctrl.sv
// ---------------------------------------------------------------------------
// spm_load_ctrl
//   Loader/run controller for the RISC_SPM memory unit. Owns the state
//   machine, the loader address pointer, the CPU reset release and the
//   sticky status flags, and tells the array who owns its single write port.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   ld_start     pulse: begin a new image load at address 0 (IDLE/RUN only)
//   ld_valid     loader word valid
//   ld_last      final word of the image, qualified by ld_valid & ld_ready
//   write        CPU write strobe
//   ld_ptr       loader write address
//   ld_ready     loader word is accepted this cycle (state LOAD)
//   sel_loader   write-port select: 1 = loader (ld_ptr/ld_data), 0 = CPU
//   mem_we       array write enable for whichever side sel_loader picks
//   cpu_rst_n    active-low CPU reset, high only while in RUN
//   load_done    sticky: image loaded and CPU released
//   wr_err       sticky: CPU write strobe seen outside RUN
//   state        current controller state (debug visibility)
//
// Handshake: a loader word transfers on a rising clk edge where
//   ld_valid & ld_ready are both 1. ld_ready depends only on state, never on
//   ld_valid, so there is no combinational path from valid to ready. When
//   ld_ready is 0 the offered word is dropped; the loader is not stalled.
// ---------------------------------------------------------------------------
module spm_load_ctrl
  import spm_pkg::*;
#(
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic                 ld_last,
  input  logic                 write,
  output logic [addr_size-1:0] ld_ptr,
  output logic                 ld_ready,
  output logic                 sel_loader,
  output logic                 mem_we,
  output logic                 cpu_rst_n,
  output logic                 load_done,
  output logic                 wr_err,
  output spm_mem_state_t       state
);

  spm_mem_state_t next_state;
  logic           ld_fire;
  logic           cpu_we;
  logic           load_enter;
  logic           ptr_full;

  // Last array slot: a word landing here finishes the image on its own.
  assign ptr_full   = (ld_ptr == {addr_size{1'b1}});
  assign load_enter = (state != LOAD) && (next_state == LOAD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ld_start) next_state = LOAD;
      LOAD: if (ld_valid && (ld_last || ptr_full)) next_state = DONE;
      DONE: next_state = RUN;
      RUN:  if (ld_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ld_ready   = 1'b0;
    sel_loader = 1'b0;
    ld_fire    = 1'b0;
    cpu_we     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      LOAD: begin
        ld_ready   = 1'b1;
        sel_loader = 1'b1;
        ld_fire    = ld_valid;
      end
      RUN: begin
        cpu_we = write;
      end
      default: ;
    endcase
    mem_we = ld_fire | cpu_we;
  end

  // Pointer, CPU reset release and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr    <= '0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      // Registered from next_state so the CPU reset edge is glitch-free and
      // lines up exactly with the edge that enters or leaves RUN.
      cpu_rst_n <= (next_state == RUN);

      if (load_enter) begin
        ld_ptr    <= '0;
        load_done <= 1'b0;
        wr_err    <= 1'b0;
      end else begin
        // Saturate at the top slot; that word ends the load, so the pointer
        // never wraps back onto word 0 within one image.
        if (ld_fire && !ptr_full) begin
          ld_ptr <= ld_ptr + 1'b1;
        end
        if (state == DONE) begin
          load_done <= 1'b1;
        end
        if (write && (state != RUN)) begin
          wr_err <= 1'b1;
        end
      end
    end
  end

endmodule : spm_load_ctrl

// File: rtl/spm_memory_unit.sv
// ---------------------------------------------------------------------------
// spm_memory_unit
//   Memory-side responder for the RISC_SPM bus. Holds the unified
//   program/data array, serves CPU reads combinationally and CPU writes on
//   clk, and hosts a byte-serial program loader that keeps the CPU in reset
//   while an image is written from address 0.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   address      CPU address (read and write)
//   data_in      CPU write data
//   write        CPU write strobe, sampled at posedge clk
//   data_out     CPU read data, mem[address] in RUN, zero otherwise
//   ld_start     pulse: begin loading an image at address 0
//   ld_valid     loader word valid
//   ld_data      loader word
//   ld_last      final word of the image
//   ld_ready     loader word accepted this cycle
//   cpu_rst_n    active-low reset to the CPU
//   load_done    sticky: image loaded and CPU released
//   wr_err       sticky: CPU write strobe seen outside RUN
// ---------------------------------------------------------------------------
module spm_memory_unit
  import spm_pkg::*;
#(
  parameter int word_size = WORD_SIZE,
  parameter int addr_size = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [addr_size-1:0] address,
  input  logic [word_size-1:0] data_in,
  input  logic                 write,
  output logic [word_size-1:0] data_out,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [word_size-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 cpu_rst_n,
  output logic                 load_done,
  output logic                 wr_err
);

  localparam int depth = 1 << addr_size;

  logic [word_size-1:0] mem [depth];

  spm_mem_state_t       state;
  logic [addr_size-1:0] ld_ptr;
  logic                 sel_loader;
  logic                 mem_we;
  logic [addr_size-1:0] wr_addr;
  logic [word_size-1:0] wr_data;

  spm_load_ctrl #(
    .addr_size (addr_size)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_last    (ld_last),
    .write      (write),
    .ld_ptr     (ld_ptr),
    .ld_ready   (ld_ready),
    .sel_loader (sel_loader),
    .mem_we     (mem_we),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .wr_err     (wr_err),
    .state      (state)
  );

  // Single write port shared between loader and CPU.
  assign wr_addr = sel_loader ? ld_ptr  : address;
  assign wr_data = sel_loader ? ld_data : data_in;

  // Contents are deliberately not reset: a partial image survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read; a write shows up from the cycle after its edge.
  assign data_out = (state == RUN) ? mem[address] : '0;

endmodule : spm_memory_unit

// File: tb/tb_spm_memory_unit.sv
// ---------------------------------------------------------------------------
// tb_spm_memory_unit
//   Self-checking bench for spm_memory_unit. Stimulus pushes the expected
//   observable vector {data_out, ld_ready, cpu_rst_n, load_done, wr_err}
//   into exp_q and raises probe; a monitor samples the DUT on the falling
//   edge and compares against the head of the queue. Expected values come
//   from a plain array model of the memory plus the model's own status flags.
// ---------------------------------------------------------------------------
module tb_spm_memory_unit;

  localparam int W = 8;
  localparam int A = 8;
  localparam int EW = W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [A-1:0] address  = '0;
  logic [W-1:0] data_in  = '0;
  logic         write    = 1'b0;
  logic [W-1:0] data_out;
  logic         ld_start = 1'b0;
  logic         ld_valid = 1'b0;
  logic [W-1:0] ld_data  = '0;
  logic         ld_last  = 1'b0;
  logic         ld_ready;
  logic         cpu_rst_n;
  logic         load_done;
  logic         wr_err;

  spm_memory_unit #(.word_size(W), .addr_size(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .data_in   (data_in),
    .write     (write),
    .data_out  (data_out),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .wr_err    (wr_err)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] ref_mem [256];
  bit           ref_ok  [256];
  logic         m_err = 1'b0;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          probe     = 1'b0;
  logic          final_chk = 1'b0;
  int            n_tests   = 0;
  int            n_fail    = 0;

  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;
  string         mon_name;

  always @(negedge clk) begin
    if (probe) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_underflow: probe raised with empty expected queue");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_got  = {data_out, ld_ready, cpu_rst_n, load_done, wr_err};
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got data_out=%h ld_ready=%b cpu_rst_n=%b load_done=%b wr_err=%b, expected data_out=%h ld_ready=%b cpu_rst_n=%b load_done=%b wr_err=%b",
                   mon_name, mon_got[EW-1:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                   mon_exp[EW-1:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
    if (final_chk) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL queue_drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic expect_now(input string nm, input logic [W-1:0] d, input logic r,
                            input logic n, input logic dn, input logic e);
    exp_q.push_back({d, r, n, dn, e});
    name_q.push_back(nm);
    probe = 1'b1;
  endtask

  // CPU write in RUN: same cycle shows the old word, next cycle the new one.
  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
    address = a;
    data_in = d;
    write   = 1'b1;
    if (ref_ok[a]) expect_now("run_write_old", ref_mem[a], 1'b0, 1'b1, 1'b1, m_err);
    tick();
    write      = 1'b0;
    ref_mem[a] = d;
    ref_ok[a]  = 1'b1;
    expect_now("run_write_new", d, 1'b0, 1'b1, 1'b1, m_err);
    tick();
  endtask

  task automatic read_check(input string nm, input logic [A-1:0] a);
    address = a;
    expect_now(nm, ref_mem[a], 1'b0, 1'b1, 1'b1, m_err);
    tick();
  endtask

  // Watchdog: the bench has no open-ended waits, this only guards a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] d;
  logic [A-1:0] a;

  initial begin
    for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;

    // Reset, then idle with stray loader traffic that must be dropped.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = W'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    expect_now("idle_after_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // First image: A1..A4 back to back, last word flagged.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid   = 1'b1;
      ld_data    = W'(8'hA1 + i);
      ld_last    = (i == 3);
      ref_mem[i] = ld_data;
      ref_ok[i]  = 1'b1;
      if (i == 0) expect_now("load_ready", '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    expect_now("done_cycle", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    address = 8'd2;
    expect_now("run_addr2_a3", 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) read_check("run_readback", A'(i));

    // CPU writes: fixed addresses used later, then random ones.
    do_write(8'h10, 8'h3C);
    do_write(8'h20, 8'hD2);
    for (int i = 0; i < 12; i++) begin
      a = A'($urandom_range(0, 255));
      d = W'($urandom);
      do_write(a, d);
    end

    // ld_start together with a CPU write: the write lands, then LOAD.
    address  = 8'h10;
    data_in  = 8'h77;
    write    = 1'b1;
    ld_start = 1'b1;
    expect_now("start_with_write", ref_mem[8'h10], 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    write    = 1'b0;
    ld_start = 1'b0;
    ref_mem[8'h10] = 8'h77;
    expect_now("reload_entered", '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    // CPU write during LOAD must not touch the array.
    address = 8'h20;
    data_in = 8'hEE;
    write   = 1'b1;
    tick();
    write = 1'b0;
    m_err = 1'b1;
    expect_now("write_in_load", '0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      ld_valid   = 1'b1;
      ld_data    = W'($urandom);
      ld_last    = (i == 1);
      ref_mem[i] = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    read_check("mem10_cpu_write_kept", 8'h10);
    read_check("mem20_untouched", 8'h20);
    read_check("short_image_word0", 8'h00);

    // Full image, ld_valid every other cycle, ld_last never set.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    m_err    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ld_valid   = 1'b1;
      ld_data    = W'($urandom);
      ref_mem[i] = ld_data;
      ref_ok[i]  = 1'b1;
      tick();
      if (i != 255) begin
        ld_valid = 1'b0;
        ld_data  = W'($urandom);
        tick();
      end
    end
    // DONE: an offered word here must be dropped, word 0 kept.
    ld_valid = 1'b1;
    ld_data  = ~ref_mem[0];
    expect_now("full_image_done", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ld_valid = 1'b0;
    read_check("full_image_word255", 8'hFF);
    read_check("full_image_word0", 8'h00);
    read_check("full_image_word128", 8'h80);
    for (int i = 0; i < 4; i++) read_check("full_image_random", A'($urandom_range(0, 255)));

    do_write(8'h40, 8'h5C);

    // Asynchronous reset in the middle of a 5-word load (after 2 words).
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid   = 1'b1;
      ld_data    = W'($urandom);
      ref_mem[i] = ld_data;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = W'($urandom);
    #2;
    rst = 1'b1;
    expect_now("rst_mid_load_async", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    expect_now("rst_stays_idle", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    // Reload one word; partial image from before reset stays in place.
    ld_start = 1'b1;
    tick();
    ld_start   = 1'b0;
    ld_valid   = 1'b1;
    ld_data    = W'($urandom);
    ld_last    = 1'b1;
    ref_mem[0] = ld_data;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    read_check("after_rst_word0", 8'h00);
    read_check("partial_word1_kept", 8'h01);
    read_check("old_word2_kept", 8'h02);

    final_chk = 1'b1;
    tick();
    final_chk = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_spm_memory_unit
